serial_sub_7bit: RTL and testbench
==================================

# serial_sub_7bit

Bit-serial 7-bit two's-complement subtractor with valid/ready handshakes on both sides. It is the inverse-operation companion to the 7-bit carry-lookahead adder and serves address-offset and compare paths where latency is tolerable and area matters. It computes D = A − B one bit per clock through a single borrow flip-flop, LSB first. It also reports the unsigned borrow-out and the signed overflow.

## Interface
- WIDTH, 7, operand/result width; verified only at 7.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands A/B presented
- in_ready  out  1  block can accept operands (IDLE only)
- A  in  7  minuend
- B  in  7  subtrahend
- out_valid  out  1  result D/Bout/V valid
- out_ready  in  1  consumer accepts result
- D  out  7  difference A − B (mod 2^7, or saturated, see Configuration)
- Bout  out  1  borrow out: 1 iff A < B unsigned
- V  out  1  signed overflow: A[6] != B[6] and D_raw[6] != A[6]

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE → RUN on in_valid & in_ready at a clock edge:
  - Capture A and B into shift registers.
  - Clear borrow flop and bit counter (3 bits).
- RUN, each edge:
  - Process LSB bits a, b with borrow br.
  - d = a ^ b ^ br.
  - br' = (~a & b) | (~(a ^ b) & br).
  - Shift d into the result register MSB end; shift A/B right.
  - Counter increments.
  - On the edge where counter==6 (7th bit): load D, Bout=br', and V; go to DONE.
- DONE → IDLE on out_ready. Otherwise hold D/Bout/V stable.
- in_valid outside IDLE is ignored; A/B are not sampled.
- D/Bout/V keep the last result after leaving DONE; consumers use them only while out_valid=1.
- Width rules:
  - All arithmetic is mod 2^7.
  - Bout is the final borrow; there is no carry-in.
  - V is computed from the unsaturated result.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, borrow=0, D=7'h00, Bout=0, V=0, out_valid=0, in_ready=1 immediately.
- Latency: accept at edge E0; bits processed at E1..E7; out_valid=1 in the cycle after E7 (7 cycles).
- Minimum period per operation: 9 cycles (accept, 7 RUN, DONE with out_ready=1, back in IDLE).
- in_ready and out_valid are decoded from registered state only; neither depends combinationally on in_valid or out_ready.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The first edge after rst_n rises may accept new operands.
- out_ready held low in DONE: stall indefinitely, outputs frozen.

## Configuration
- SUB_SAT_EN defined:
  - On V=1 the loaded D saturates: 7'h3F if A[6]=0 (positive overflow), 7'h40 if A[6]=1 (negative overflow).
  - Bout and V are unchanged.
- SUB_SAT_EN undefined: D is the wrapped mod-2^7 result. No saturation logic is present.

## Test plan
- A=0x05, B=0x03, accept at E0, out_ready=1 → out_valid at cycle after E7; D=0x02, Bout=0, V=0; in_ready=1 one cycle later.
- A=0x03, B=0x05 → D=0x7E, Bout=1, V=0.
- A=0x3F, B=0x7F (63 − (−1)) → V=1, Bout=1; D=0x40 without SUB_SAT_EN, D=0x3F with it.
- A=0x40, B=0x01 (−64 − 1) → V=1, Bout=0; D=0x3F without SUB_SAT_EN, D=0x40 with it.
- Result A=0x10, B=0x10 with out_ready low for 5 cycles → D=0x00 and out_valid=1 held; in_ready stays 0; in_valid pulses ignored; IDLE on first out_ready.
- rst_n pulsed low during RUN bit 3 → out_valid never rises; in_ready=1 during reset. A follow-up A=0x7F, B=0x00 yields D=0x7F, Bout=0, V=0.

Source files
------------

// File: rtl/serial_sub_7bit.sv
// Bit-serial 7-bit two's-complement subtractor (D = A - B, LSB first) with
// valid/ready handshakes. Optional macro SUB_SAT_EN saturates D on signed overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one bit per clock through the borrow flop, 7 cycles
// DONE  | result held, out_valid=1 until out_ready
module serial_sub_7bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] A,
  input  logic [6:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] D,
  output logic       Bout,
  output logic       V
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       br_q, br_d;
  logic [6:0] a_sh_q, a_sh_d;
  logic [6:0] b_sh_q, b_sh_d;
  logic [6:0] res_q, res_d;
  logic       a6_q, a6_d;
  logic       b6_q, b6_d;
  logic [6:0] d_q, d_d;
  logic       bout_q, bout_d;
  logic       v_q, v_d;

  logic       bit_a, bit_b, bit_d, br_next, v_raw;
  logic [6:0] d_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    a6_d    = a6_q;
    b6_d    = b6_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;

    bit_a   = a_sh_q[0];
    bit_b   = b_sh_q[0];
    bit_d   = bit_a ^ bit_b ^ br_q;
    br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    d_raw   = {bit_d, res_q[6:1]};
    // Sign bits are kept aside because the operand registers shift them out.
    v_raw   = (a6_q ^ b6_q) & (d_raw[6] ^ a6_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          a6_d    = A[6];
          b6_d    = B[6];
          br_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = d_raw;
        a_sh_d = {1'b0, a_sh_q[6:1]};
        b_sh_d = {1'b0, b_sh_q[6:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          bout_d = br_next;
          v_d    = v_raw;
`ifdef SUB_SAT_EN
          if (v_raw) d_d = a6_q ? 7'h40 : 7'h3F;
          else       d_d = d_raw;
`else
          d_d    = d_raw;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      br_q    <= 1'b0;
      a_sh_q  <= 7'h00;
      b_sh_q  <= 7'h00;
      res_q   <= 7'h00;
      a6_q    <= 1'b0;
      b6_q    <= 1'b0;
      d_q     <= 7'h00;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      a6_q    <= a6_d;
      b6_q    <= b6_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign Bout      = bout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_serial_sub_7bit.sv
// Directed self-checking bench for serial_sub_7bit; expected values are
// hand-computed, with SUB_SAT_EN selecting the saturated expectations.
module tb_serial_sub_7bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] A = 7'h00;
  logic [6:0] B = 7'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] D;
  logic       Bout;
  logic       V;

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub_7bit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({D, Bout, V} !== 9'h000) begin n_bad++; $display("FAIL reset_outputs got D=%h Bout=%b V=%b want 00/0/0", D, Bout, V); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Call at #1 after a posedge with the DUT in IDLE and out_ready=1.
  task automatic run_op(input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] ed, input logic eb, input logic ev,
                        input string name);
    bit early = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_at_accept got %b want 1", name, in_ready); end
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1;
    end
    n_cmp++; if (early) begin n_bad++; $display("FAIL %s_run_flags got early out_valid/in_ready want 0 during RUN", name); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_latency out_valid got %b want 1", name, out_valid); end
    n_cmp++; if (D !== ed)   begin n_bad++; $display("FAIL %s_D got %h want %h", name, D, ed); end
    n_cmp++; if (Bout !== eb) begin n_bad++; $display("FAIL %s_Bout got %b want %b", name, Bout, eb); end
    n_cmp++; if (V !== ev)   begin n_bad++; $display("FAIL %s_V got %b want %b", name, V, ev); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_return_idle got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_vectors;
    run_op(7'h05, 7'h03, 7'h02, 1'b0, 1'b0, "sub_5_3");
    run_op(7'h03, 7'h05, 7'h7E, 1'b1, 1'b0, "sub_3_5");
`ifdef SUB_SAT_EN
    run_op(7'h3F, 7'h7F, 7'h3F, 1'b1, 1'b1, "pos_ovf");
    run_op(7'h40, 7'h01, 7'h40, 1'b0, 1'b1, "neg_ovf");
`else
    run_op(7'h3F, 7'h7F, 7'h40, 1'b1, 1'b1, "pos_ovf");
    run_op(7'h40, 7'h01, 7'h3F, 1'b0, 1'b1, "neg_ovf");
`endif
  endtask

  task automatic test_reset_mid_run;
    bit rose = 0;
    A = 7'h55; B = 7'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({D, Bout, V} !== 9'h000) begin n_bad++; $display("FAIL midrst_outputs got D=%h Bout=%b V=%b want 00/0/0", D, Bout, V); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) rose = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) rose = 1;
    end
    n_cmp++; if (rose) begin n_bad++; $display("FAIL midrst_no_output got out_valid=1 want 0 after abort"); end
    run_op(7'h7F, 7'h00, 7'h7F, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_stall;
    bit held = 1;
    out_ready = 1'b0;
    A = 7'h10; B = 7'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 7'h00 || Bout !== 1'b0 || V !== 1'b0) held = 0;
      in_valid = (i == 1 || i == 3);
      A = 7'h7F; B = 7'h01;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (!held) begin n_bad++; $display("FAIL stall_hold got out_valid=%b in_ready=%b D=%h want 1/0/00", out_valid, in_ready, D); end
    n_cmp++; if (out_valid !== 1'b1 || D !== 7'h00) begin n_bad++; $display("FAIL stall_end got out_valid=%b D=%h want 1/00", out_valid, D); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_cmp++; if (D !== 7'h00) begin n_bad++; $display("FAIL stall_keep_D got %h want 00", D); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid_run();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
